// File: rtl/wb_decoder_pkg.sv
// rtl/wb_decoder_pkg.sv - shared state type, bus widths and index-width helper for wb_decoder
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  // Bits needed to encode n distinct indices; never less than 1 so a
  // single-slave build still has a legal index vector.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/wb_decoder_addr_match.sv
// rtl/wb_decoder_addr_match.sv - combinational base/mask address decode with lowest-index priority
module wb_addr_match
  import wb_pkg::*;
#(
  parameter int                       NSLAVE      = 3,
  parameter int                       IW          = 2,
  parameter logic [NSLAVE*WB_AW-1:0]  BASE        = '0,
  parameter logic [NSLAVE*WB_AW-1:0]  MASK        = '0,
  parameter int                       DEFAULT_IDX = -1
) (
  input  logic [WB_AW-1:0] i_adr,
  output logic             o_hit,
  output logic [IW-1:0]    o_idx
);

  // Scan from the top slot down so the lowest matching index is the one left standing.
  always_comb begin
    o_hit = 1'b0;
    o_idx = '0;
    for (int i = NSLAVE - 1; i >= 0; i--) begin
      if ((i_adr & MASK[i*WB_AW +: WB_AW]) ==
          (BASE[i*WB_AW +: WB_AW] & MASK[i*WB_AW +: WB_AW])) begin
        o_hit = 1'b1;
        o_idx = IW'(i);
      end
    end
    if (!o_hit && (DEFAULT_IDX >= 0)) begin
      o_hit = 1'b1;
      o_idx = IW'(DEFAULT_IDX);
    end
  end

endmodule

// File: rtl/wb_decoder.sv
// rtl/wb_decoder.sv - registered Wishbone single-master decoder; WB_DECODER_TIMEOUT_EN adds a BUSY watchdog
module wb_decoder
  import wb_pkg::*;
#(
  parameter int                       NSLAVE      = 3,
  parameter logic [NSLAVE*WB_AW-1:0]  BASE        = {32'h0000_0000, 32'hEEEE_0000, 32'hFFFF_0000},
  parameter logic [NSLAVE*WB_AW-1:0]  MASK        = {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFFF},
  parameter int                       DEFAULT_IDX = -1,
  parameter int                       TIMEOUT     = 255
) (
  input  logic                      CLK_I,
  input  logic                      RST_I,
  input  logic                      M_STB_I,
  input  logic                      M_WE_I,
  input  logic [WB_AW-1:0]          M_ADR_I,
  input  logic [WB_DW-1:0]          M_DAT_I,
  output logic [WB_DW-1:0]          M_DAT_O,
  output logic                      M_ACK_O,
  output logic                      M_ERR_O,
  output logic [NSLAVE-1:0]         S_STB_O,
  output logic                      S_WE_O,
  output logic [WB_AW-1:0]          S_ADR_O,
  output logic [WB_DW-1:0]          S_DAT_O,
  input  logic [NSLAVE*WB_DW-1:0]   S_DAT_I,
  input  logic [NSLAVE-1:0]         S_ACK_I
);

  localparam int IW = clog2(NSLAVE);

  wb_state_e           r_state;
  wb_state_e           w_state_nxt;
  logic [IW-1:0]       r_idx;
  logic [NSLAVE-1:0]   r_stb;
  logic                r_we;
  logic [WB_AW-1:0]    r_adr;
  logic [WB_DW-1:0]    r_sdat;
  logic [WB_DW-1:0]    r_mdat;
  logic                r_ack;
  logic                r_err;
  logic                r_fail;

  logic                w_hit;
  logic [IW-1:0]       w_idx;
  logic                w_sel_ack;
  logic [WB_DW-1:0]    w_sel_dat;
  logic                w_timeout;
  logic                w_start;
  logic                w_miss;
  logic                w_done_ack;
  logic                w_done_err;

  wb_addr_match #(
    .NSLAVE      (NSLAVE),
    .IW          (IW),
    .BASE        (BASE),
    .MASK        (MASK),
    .DEFAULT_IDX (DEFAULT_IDX)
  ) u_match (
    .i_adr (M_ADR_I),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  // Only the slave that owns the transaction may complete it.
  assign w_sel_ack = S_ACK_I[r_idx];
  assign w_sel_dat = S_DAT_I[int'(r_idx) * WB_DW +: WB_DW];

`ifdef WB_DECODER_TIMEOUT_EN
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);
  logic [15:0] r_cnt;

  // Fires on the BUSY cycle whose count would reach the limit.
  assign w_timeout = ((r_cnt + 16'd1) == LP_TIMEOUT);
`else
  // Never fires: without the watchdog BUSY waits for the slave indefinitely.
  assign w_timeout = (TIMEOUT < 0);
`endif

  // Next-state and transfer decisions; an ACK on the timeout cycle takes precedence.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_miss      = 1'b0;
    w_done_ack  = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      IDLE: begin
        if (M_STB_I) begin
          if (w_hit) begin
            w_start     = 1'b1;
            w_state_nxt = BUSY;
          end else begin
            w_miss      = 1'b1;
            w_state_nxt = RESP;
          end
        end
      end
      BUSY: begin
        if (w_sel_ack) begin
          w_done_ack  = 1'b1;
          w_state_nxt = RESP;
        end else if (w_timeout) begin
          w_done_err  = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Latched request, slave strobe, captured read data and one-cycle response pulses.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_idx  <= '0;
      r_stb  <= '0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_sdat <= '0;
      r_mdat <= '0;
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_fail <= 1'b0;
`ifdef WB_DECODER_TIMEOUT_EN
      r_cnt  <= '0;
`endif
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      if (w_start) begin
        r_idx  <= w_idx;
        r_we   <= M_WE_I;
        r_adr  <= M_ADR_I;
        r_sdat <= M_DAT_I;
        r_stb  <= NSLAVE'(1) << w_idx;
`ifdef WB_DECODER_TIMEOUT_EN
        r_cnt  <= '0;
`endif
      end
`ifdef WB_DECODER_TIMEOUT_EN
      if (r_state == BUSY) r_cnt <= r_cnt + 16'd1;
`endif
      if (w_miss) r_fail <= 1'b1;
      if (w_done_ack) begin
        r_mdat <= w_sel_dat;
        r_stb  <= '0;
        r_fail <= 1'b0;
      end
      if (w_done_err) begin
        r_stb  <= '0;
        r_fail <= 1'b1;
      end
      if (r_state == RESP) begin
        r_ack <= !r_fail;
        r_err <= r_fail;
        if (r_fail) r_mdat <= '0;
      end
    end
  end

  assign M_DAT_O = r_mdat;
  assign M_ACK_O = r_ack;
  assign M_ERR_O = r_err;
  assign S_STB_O = r_stb;
  assign S_WE_O  = r_we;
  assign S_ADR_O = r_adr;
  assign S_DAT_O = r_sdat;

endmodule

// File: tb/tb_wb_decoder.sv
// tb/tb_wb_decoder.sv - self-checking bench for wb_decoder (timeout cases need WB_DECODER_TIMEOUT_EN)
module tb_wb_decoder;

  localparam int NC   = 1024;
  localparam int T_TO = 8;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] sd;
    int          w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_stb, m_we;
  logic [31:0] m_adr, m_dat;
  logic [31:0] m_dat_o;
  logic        m_ack, m_err;
  logic [2:0]  s_stb;
  logic        s_we;
  logic [31:0] s_adr, s_dat;
  logic [95:0] s_dat_i;
  logic [2:0]  s_ack_i;

  logic [31:0] d_dat_o;
  logic        d_ack, d_err;
  logic [2:0]  d_stb;
  logic        d_we;
  logic [31:0] d_adr, d_dat;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int last_n0 = 0;

  bit [2:0]  e_stb [NC];
  bit        e_ack [NC], e_err [NC], e_mchk [NC], e_schk [NC], e_zero [NC], e_we [NC];
  bit [31:0] e_mdat [NC], e_adr [NC], e_sdat [NC];
  bit [2:0]  l_stb [NC], ld_stb [NC];
  bit        l_ack [NC], l_err [NC], l_swe [NC], ld_ack [NC];
  bit [31:0] l_mdat [NC], l_sdat [NC], ld_mdat [NC];

  wb_decoder #(
    .NSLAVE      (3),
    .BASE        ({32'h0000_0000, 32'hEEEE_0000, 32'hFFFF_0000}),
    .MASK        ({32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_FFFF}),
    .DEFAULT_IDX (-1),
    .TIMEOUT     (T_TO)
  ) dut (
    .CLK_I (clk), .RST_I (rst),
    .M_STB_I (m_stb), .M_WE_I (m_we), .M_ADR_I (m_adr), .M_DAT_I (m_dat),
    .M_DAT_O (m_dat_o), .M_ACK_O (m_ack), .M_ERR_O (m_err),
    .S_STB_O (s_stb), .S_WE_O (s_we), .S_ADR_O (s_adr), .S_DAT_O (s_dat),
    .S_DAT_I (s_dat_i), .S_ACK_I (s_ack_i)
  );

  // Second decoder: default slot 0, and slot 2 (EEE0_0000/FFF0_0000) overlaps slot 1.
  wb_decoder #(
    .NSLAVE      (3),
    .BASE        ({32'hEEEE_0000, 32'hEEEE_0000, 32'hFFFF_0000}),
    .MASK        ({32'hFFF0_0000, 32'hFFFF_0000, 32'hFFFF_FFFF}),
    .DEFAULT_IDX (0),
    .TIMEOUT     (T_TO)
  ) dut_d (
    .CLK_I (clk), .RST_I (rst),
    .M_STB_I (m_stb), .M_WE_I (m_we), .M_ADR_I (m_adr), .M_DAT_I (m_dat),
    .M_DAT_O (d_dat_o), .M_ACK_O (d_ack), .M_ERR_O (d_err),
    .S_STB_O (d_stb), .S_WE_O (d_we), .S_ADR_O (d_adr), .S_DAT_O (d_dat),
    .S_DAT_I ({32'hC2C2_0002, 32'hC1C1_0001, 32'hC0C0_0000}), .S_ACK_I (d_stb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  // Slot table in index order; slot 0 is the least-significant word of the packed BASE/MASK.
  function automatic int model_idx(input logic [31:0] a);
    logic [31:0] b [3];
    logic [31:0] m [3];
    b[0] = 32'hFFFF_0000; m[0] = 32'hFFFF_FFFF;
    b[1] = 32'hEEEE_0000; m[1] = 32'hFFFF_0000;
    b[2] = 32'h0000_0000; m[2] = 32'hFFFF_0000;
    for (int i = 0; i < 3; i++)
      if (((a ^ b[i]) & m[i]) == 32'h0) return i;
    return -1;
  endfunction

  // Per-cycle comparison against the planned timeline, plus a log for literal checks.
  always @(negedge clk) begin
    if (cyc < NC) begin
      l_stb[cyc]   = s_stb;   l_ack[cyc]  = m_ack;   l_err[cyc]  = m_err;
      l_mdat[cyc]  = m_dat_o; l_sdat[cyc] = s_dat;   l_swe[cyc]  = s_we;
      ld_stb[cyc]  = d_stb;   ld_ack[cyc] = d_ack;   ld_mdat[cyc] = d_dat_o;
      chk("s_stb", {29'h0, s_stb}, {29'h0, e_stb[cyc]});
      chk("m_ack", {31'h0, m_ack}, {31'h0, e_ack[cyc]});
      chk("m_err", {31'h0, m_err}, {31'h0, e_err[cyc]});
      if (e_mchk[cyc]) chk("m_dat", m_dat_o, e_mdat[cyc]);
      if (e_schk[cyc]) begin
        chk("s_we", {31'h0, s_we}, {31'h0, e_we[cyc]});
        chk("s_adr", s_adr, e_adr[cyc]);
        chk("s_dat", s_dat, e_sdat[cyc]);
      end
      if (e_zero[cyc]) begin
        chk("zero_m_dat", m_dat_o, 32'h0);
        chk("zero_s_we", {31'h0, s_we}, 32'h0);
        chk("zero_s_adr", s_adr, 32'h0);
        chk("zero_s_dat", s_dat, 32'h0);
      end
    end
  end

  // Plans the expected timeline from the decode rule, then plays master and slave.
  task automatic do_txn(input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [31:0] sd, input int w, input bit silent);
    int n0, idx, r, last;
    logic [2:0] oh;
    n0  = cyc + 1;
    idx = model_idx(adr);
    oh  = (idx >= 0) ? 3'(1 << idx) : 3'b000;
    if (idx < 0) begin
      r = n0 + 1;
    end else begin
      last = silent ? n0 + T_TO - 1 : n0 + w;
      for (int c = n0; c <= last; c++) begin
        e_stb[c] = oh; e_schk[c] = 1'b1; e_we[c] = we; e_adr[c] = adr; e_sdat[c] = dat;
      end
      r = last + 2;
    end
    e_mchk[r] = 1'b1;
    if (idx < 0 || silent) begin e_err[r] = 1'b1; e_mdat[r] = 32'h0; end
    else begin e_ack[r] = 1'b1; e_mdat[r] = sd; end
    last_n0 = n0;
    m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = dat;
    for (int i = 0; i < 3; i++)
      s_dat_i[32*i +: 32] = (i == idx) ? sd : (32'hBAD0_0000 | 32'(i));
    while (cyc < r) begin
      s_ack_i = 3'($urandom_range(0, 7)) & ~oh;
      if (idx >= 0 && !silent && cyc == n0 + w) s_ack_i = s_ack_i | oh;
      @(negedge clk);
    end
    s_ack_i = 3'b000;
    m_stb   = 1'b0;
  endtask

  task automatic idle(input int k);
    m_stb = 1'b0; s_ack_i = 3'b000;
    repeat (k) @(negedge clk);
  endtask

  vec_t tbl [7];
  int   n;

  initial begin
    tbl[0] = '{1'b0, 32'h0000_FFFC, 32'h0,         32'hCAFE_0001, 0};
    tbl[1] = '{1'b1, 32'hEEEE_FFFF, 32'h1111_2222, 32'h0000_0000, 2};
    tbl[2] = '{1'b0, 32'h0001_0000, 32'h0,         32'h0,         0};
    tbl[3] = '{1'b0, 32'hFFFF_0001, 32'h0,         32'h0,         0};
    tbl[4] = '{1'b1, 32'h0000_0000, 32'hFEED_BEEF, 32'h7777_0000, 1};
    tbl[5] = '{1'b0, 32'hFFFF_0000, 32'h0,         32'h8765_4321, 3};
    tbl[6] = '{1'b0, 32'hEEEF_0000, 32'h0,         32'h0,         0};

    rst = 1'b1; m_stb = 1'b0; m_we = 1'b0; m_adr = '0; m_dat = '0;
    s_ack_i = '0; s_dat_i = '0;
    for (int c = 1; c <= 6; c++) e_zero[c] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(3);

    chk("model_ffff0000", model_idx(32'hFFFF_0000), 32'd0);
    chk("model_eeee0010", model_idx(32'hEEEE_0010), 32'd1);
    chk("model_00000004", model_idx(32'h0000_0004), 32'd2);
    chk("model_10000000", model_idx(32'h1000_0000), 32'hFFFF_FFFF);

    do_txn(1'b1, 32'hFFFF_0000, 32'h0000_00AA, 32'h5A5A_5A5A, 0, 1'b0);
    n = last_n0; idle(4);
    chk("wr_stb_c1", {29'h0, l_stb[n]}, 32'h1);
    chk("wr_stb_c2", {29'h0, l_stb[n+1]}, 32'h0);
    chk("wr_ack_c3", {31'h0, l_ack[n+2]}, 32'h1);
    chk("wr_s_dat", l_sdat[n], 32'h0000_00AA);
    chk("wr_s_we", {31'h0, l_swe[n]}, 32'h1);

    do_txn(1'b0, 32'hEEEE_0010, 32'h0, 32'h1234_5678, 4, 1'b0);
    n = last_n0; idle(4);
    chk("rd_no_early_ack", {31'h0, l_ack[n+5]}, 32'h0);
    chk("rd_ack", {31'h0, l_ack[n+6]}, 32'h1);
    chk("rd_dat", l_mdat[n+6], 32'h1234_5678);
    chk("rd_ack_1cyc", {31'h0, l_ack[n+7]}, 32'h0);

    do_txn(1'b0, 32'h1000_0000, 32'h0, 32'h0, 0, 1'b0);
    n = last_n0; idle(4);
    chk("miss_no_stb", {29'h0, l_stb[n]}, 32'h0);
    chk("miss_err", {31'h0, l_err[n+1]}, 32'h1);
    chk("miss_dat", l_mdat[n+1], 32'h0);
    chk("dflt_stb", {29'h0, ld_stb[n]}, 32'h1);
    chk("dflt_ack", {31'h0, ld_ack[n+2]}, 32'h1);
    chk("dflt_dat", ld_mdat[n+2], 32'hC0C0_0000);

    do_txn(1'b1, 32'hEEEE_0010, 32'h0000_0055, 32'h0, 0, 1'b0);
    n = last_n0; idle(4);
    chk("ovl_low_wins", {29'h0, ld_stb[n]}, 32'h2);
    chk("ovl_low_dat", ld_mdat[n+2], 32'hC1C1_0001);
    do_txn(1'b0, 32'hEEE1_0000, 32'h0, 32'h0, 0, 1'b0);
    n = last_n0; idle(4);
    chk("ovl_wide_stb", {29'h0, ld_stb[n]}, 32'h4);
    chk("ovl_wide_ack", {31'h0, ld_ack[n+2]}, 32'h1);
    chk("ovl_wide_dat", ld_mdat[n+2], 32'hC2C2_0002);

    for (int i = 0; i < 7; i++)
      do_txn(tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sd, tbl[i].w, 1'b0);
    idle(4);

    n = cyc + 1;
    e_stb[n] = 3'b100; e_schk[n] = 1'b1; e_we[n] = 1'b0; e_adr[n] = 32'h0000_0040; e_sdat[n] = 32'h0;
    m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0000_0040; m_dat = 32'h0;
    @(negedge clk);
    rst = 1'b1; m_stb = 1'b0;
    for (int c = n + 1; c <= n + 5; c++) e_zero[c] = 1'b1;
    @(negedge clk);
    rst = 1'b0; s_ack_i = 3'b100; s_dat_i[64 +: 32] = 32'hBADD_A7A0;
    @(negedge clk);
    s_ack_i = 3'b000;
    idle(4);
    chk("rst_stb_off", {29'h0, l_stb[n+1]}, 32'h0);
    chk("rst_no_ack", {31'h0, l_ack[n+2] | l_ack[n+3]}, 32'h0);
    do_txn(1'b0, 32'h0000_0100, 32'h0, 32'h0BAD_F00D, 1, 1'b0);
    n = last_n0; idle(4);
    chk("post_rst_ack", {31'h0, l_ack[n+3]}, 32'h1);
    chk("post_rst_dat", l_mdat[n+3], 32'h0BAD_F00D);

`ifdef WB_DECODER_TIMEOUT_EN
    do_txn(1'b0, 32'h0000_0004, 32'h0, 32'h0, 0, 1'b1);
    n = last_n0; idle(4);
    chk("to_stb_last", {29'h0, l_stb[n+7]}, 32'h4);
    chk("to_stb_drop", {29'h0, l_stb[n+8]}, 32'h0);
    chk("to_no_early_err", {31'h0, l_err[n+8]}, 32'h0);
    chk("to_err", {31'h0, l_err[n+9]}, 32'h1);
    do_txn(1'b0, 32'h0000_0008, 32'h0, 32'hACED_0007, T_TO - 1, 1'b0);
    n = last_n0; idle(4);
    chk("to_ack_wins", {31'h0, l_ack[n+9]}, 32'h1);
    chk("to_ack_no_err", {31'h0, l_err[n+9]}, 32'h0);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
